// File: rtl/fu_issue_queue.sv
// fu_issue_queue: in-order issue buffer in front of functional_unit.
// Ops are queued, issued one at a time from glitch-free FU_* registers, and the
// FU result is captured with the op's tag into a small result FIFO.
// Optional build macro FUIQ_PERF_EN adds the PERF_ISSUED / PERF_STALL counters;
// without it both ports read 16'h0000.
// Handshakes (IN_VALID/IN_READY, RES_VALID/RES_READY): a transfer happens on the
// rising CLOCK edge where valid and ready are both high; valid never waits on ready.
module fu_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int RES_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [31:0]              IN_A,
    input  logic [31:0]              IN_B,
    input  logic [31:0]              IN_C,
    input  logic [4:0]               IN_INST,
    input  logic                     IN_CI,
    input  logic [TAG_W-1:0]         IN_TAG,
    output logic [31:0]              FU_A,
    output logic [31:0]              FU_B,
    output logic [31:0]              FU_C,
    output logic [4:0]               FU_INST,
    output logic                     FU_CI,
    input  logic [31:0]              FU_Z,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic [31:0]              RES_DATA,
    output logic [TAG_W-1:0]         RES_TAG,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [15:0]              PERF_ISSUED,
    output logic [15:0]              PERF_STALL,
    output logic [1:0]               DBG_STATE
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RC_W = $clog2(RES_DEPTH + 1);
    localparam int RP_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [RC_W:0]   RES_LIM  = (RC_W + 1)'(RES_DEPTH);
    localparam logic [RP_W-1:0] RES_LAST = RP_W'(RES_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_SAMPLE = 2'd2} state_t;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      c;
        logic [4:0]       inst;
        logic             ci;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t             iq_mem [DEPTH];
    logic [AW-1:0]   iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    state_t          state_q, state_d;
    op_t             fu_q, fu_d;     // fu_q.tag is the tag of the op in flight

    logic [31:0]      res_data_mem [RES_DEPTH];
    logic [TAG_W-1:0] res_tag_mem  [RES_DEPTH];
    logic [RP_W-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [RC_W-1:0]  res_count_q, res_count_d;

    op_t          head;
    logic         iq_empty, head_nop, push, pop, load, res_wr, res_pop, issue_ok;
    logic [RC_W:0] res_occ;

    assign head      = iq_mem[iq_rd_q];
    assign iq_empty  = (count_q == '0);
    assign head_nop  = (head.inst[4:2] == 3'b000);
    assign push      = IN_VALID & in_ready_q;
    assign RES_VALID = (res_count_q != '0);
    assign res_pop   = RES_VALID & RES_READY;

    // Issue only if the result FIFO still has room once the SAMPLE write lands.
    always_comb begin
        res_occ  = {1'b0, res_count_q} + (RC_W + 1)'(state_q == S_SAMPLE) - (RC_W + 1)'(res_pop);
        issue_ok = (res_occ < RES_LIM);
    end

    // Issue FSM next state: drop NOP heads, load FU_* from a non-NOP head, write result in SAMPLE.
    always_comb begin
        state_d = state_q;
        fu_d    = fu_q;
        pop     = 1'b0;
        load    = 1'b0;
        res_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!iq_empty) begin
                    if (head_nop) begin
                        pop = 1'b1;
                    end else if (issue_ok) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end
                end
            end
            S_EXEC: state_d = S_SAMPLE;
            S_SAMPLE: begin
                res_wr = 1'b1;
                if (!iq_empty && !head_nop && issue_ok) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    fu_d.inst = 5'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            fu_d    = head;
            state_d = S_EXEC;
        end
    end

    // Queue pointer/occupancy and result FIFO bookkeeping.
    always_comb begin
        iq_wr_d     = push ? iq_wr_q + 1'b1 : iq_wr_q;
        iq_rd_d     = pop ? iq_rd_q + 1'b1 : iq_rd_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        in_ready_d  = (count_d != FULL_CNT);
        res_wr_d    = res_wr ? ((res_wr_q == RES_LAST) ? '0 : res_wr_q + 1'b1) : res_wr_q;
        res_rd_d    = res_pop ? ((res_rd_q == RES_LAST) ? '0 : res_rd_q + 1'b1) : res_rd_q;
        res_count_d = res_count_q + RC_W'(res_wr) - RC_W'(res_pop);
    end

    // Control state registers; reset empties everything and discards the op in flight.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            fu_q        <= '0;
            iq_wr_q     <= '0;
            iq_rd_q     <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fu_q        <= fu_d;
            iq_wr_q     <= iq_wr_d;
            iq_rd_q     <= iq_rd_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            res_count_q <= res_count_d;
        end
    end

    // Storage arrays; contents are only meaningful under the valid pointers.
    always_ff @(posedge CLOCK) begin
        if (push) iq_mem[iq_wr_q] <= '{a: IN_A, b: IN_B, c: IN_C, inst: IN_INST, ci: IN_CI, tag: IN_TAG};
        if (res_wr) begin
            res_data_mem[res_wr_q] <= FU_Z;
            res_tag_mem[res_wr_q]  <= fu_q.tag;
        end
    end

    assign IN_READY  = in_ready_q;
    assign COUNT     = count_q;
    assign FU_A      = fu_q.a;
    assign FU_B      = fu_q.b;
    assign FU_C      = fu_q.c;
    assign FU_INST   = fu_q.inst;
    assign FU_CI     = fu_q.ci;
    assign RES_DATA  = RES_VALID ? res_data_mem[res_rd_q] : 32'h0;
    assign RES_TAG   = RES_VALID ? res_tag_mem[res_rd_q] : '0;
    assign DBG_STATE = state_q;

`ifdef FUIQ_PERF_EN
    logic [15:0] issued_q, issued_d, stall_q, stall_d;
    logic        stall_cyc;

    // Saturating counters: issued ops and cycles a ready non-NOP head was held back.
    always_comb begin
        stall_cyc = (state_q != S_EXEC) && !iq_empty && !head_nop && !issue_ok;
        issued_d  = (load && issued_q != 16'hFFFF) ? issued_q + 16'd1 : issued_q;
        stall_d   = (stall_cyc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // Performance counter registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign PERF_ISSUED = issued_q;
    assign PERF_STALL  = stall_q;
`else
    assign PERF_ISSUED = 16'h0000;
    assign PERF_STALL  = 16'h0000;
`endif

endmodule

// File: tb/tb_fu_issue_queue.sv
// Directed bench for fu_issue_queue with a behavioural functional_unit model.
module tb_fu_issue_queue;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, in_ready, in_ci, fu_ci, res_valid, res_ready;
    logic [31:0]      in_a, in_b, in_c, fu_a, fu_b, fu_c, res_data;
    logic [31:0]      fu_z = 32'h0;
    logic [4:0]       in_inst, fu_inst;
    logic [TAG_W-1:0] in_tag, res_tag;
    logic [2:0]       count;
    logic [15:0]      perf_issued, perf_stall;
    logic [1:0]       dbg_state;

    fu_issue_queue #(.DEPTH(4), .RES_DEPTH(2), .TAG_W(TAG_W)) dut (
        .CLOCK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_A(in_a), .IN_B(in_b), .IN_C(in_c), .IN_INST(in_inst), .IN_CI(in_ci), .IN_TAG(in_tag),
        .FU_A(fu_a), .FU_B(fu_b), .FU_C(fu_c), .FU_INST(fu_inst), .FU_CI(fu_ci), .FU_Z(fu_z),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data), .RES_TAG(res_tag),
        .COUNT(count), .PERF_ISSUED(perf_issued), .PERF_STALL(perf_stall), .DBG_STATE(dbg_state)
    );

    // functional_unit model: captures on any edge where a unit is enabled.
    always @(posedge clk) begin
        if (fu_inst[4])      fu_z <= fu_a + fu_b + {31'b0, fu_ci};
        else if (fu_inst[3]) fu_z <= fu_a << fu_b[4:0];
        else if (fu_inst[2]) fu_z <= fu_a * fu_b + fu_c;
    end

    int checks = 0, failures = 0, cyc = 0, res_seen = 0, prev_cyc = 0;
    bit gap_on = 1'b0, prev_ok = 1'b0;
    logic [TAG_W+31:0] exp_q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(logic [TAG_W-1:0] tag, logic [31:0] data);
        exp_q.push_back({tag, data});
    endtask

    // One clock: score the result consumed at the coming edge, then settle past the edge.
    task automatic step();
        logic [TAG_W+31:0] e;
        if (res_valid && res_ready) begin
            res_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL res_unexpected observed_tag=%0h expected=none", res_tag);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_tag", 32'(res_tag), 32'(e[TAG_W+31:32]));
                chk("res_data", res_data, e[31:0]);
            end
            if (gap_on) begin
                if (prev_ok) chk("res_gap", 32'(cyc - prev_cyc), 32'd2);
                prev_ok  = 1'b1;
                prev_cyc = cyc;
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic push(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [4:0] inst,
                        logic ci, logic [TAG_W-1:0] tag);
        bit acc, done;
        done = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_inst = inst; in_ci = ci; in_tag = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            acc = in_ready;
            step();
            done = acc;
        end
        in_valid = 1'b0;
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL push_timeout observed=blocked expected=accepted tag=%0h", tag);
        end
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && count == 3'd0 && dbg_state == 2'd0 && !res_valid) break;
            step();
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_inst = '0; in_ci = 1'b0; in_tag = '0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fu_inst", 32'(fu_inst), 32'd0);
        chk("rst_fu_a", fu_a, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_perf_issued", 32'(perf_issued), 32'd0);
        chk("rst_perf_stall", 32'(perf_stall), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_state", 32'(dbg_state), 32'd0);

        // Single ALU op, latency trace.
        expect_res(4'd1, 32'd8);
        push(32'd5, 32'd3, 32'd0, 5'b10000, 1'b0, 4'd1);
        chk("s1_k_count", 32'(count), 32'd1);
        chk("s1_k_fu_inst", 32'(fu_inst), 32'd0);
        step();
        chk("s1_k1_fu_inst", 32'(fu_inst), 32'h10);
        chk("s1_k1_fu_a", fu_a, 32'd5);
        chk("s1_k1_fu_b", fu_b, 32'd3);
        chk("s1_k1_count", 32'(count), 32'd0);
        chk("s1_k1_state", 32'(dbg_state), 32'd1);
        step();
        chk("s1_k2_fu_inst", 32'(fu_inst), 32'h10);
        chk("s1_k2_state", 32'(dbg_state), 32'd2);
        chk("s1_k2_res_valid", 32'(res_valid), 32'd0);
        step();
        chk("s1_k3_fu_inst", 32'(fu_inst), 32'd0);
        chk("s1_k3_res_valid", 32'(res_valid), 32'd1);
        chk("s1_k3_res_data", res_data, 32'd8);
        chk("s1_k3_res_tag", 32'(res_tag), 32'd1);
        res_ready = 1'b1;
        step();
        chk("s1_popped", 32'(res_valid), 32'd0);

        // Four back-to-back ops, one result every 2 cycles in tag order.
        gap_on = 1'b1; prev_ok = 1'b0;
        expect_res(4'd0, 32'd31);
        expect_res(4'd1, 32'd16);
        expect_res(4'd2, 32'd23);
        expect_res(4'd3, 32'd0);
        push(32'd10, 32'd20, 32'd0, 5'b10000, 1'b1, 4'd0);
        push(32'd1, 32'd4, 32'd0, 5'b01000, 1'b0, 4'd1);
        push(32'd3, 32'd7, 32'd2, 5'b00100, 1'b0, 4'd2);
        push(32'hFFFF_FFFF, 32'd1, 32'd0, 5'b10000, 1'b0, 4'd3);
        drain("s2_drain");
        gap_on = 1'b0;

        // Result back-pressure: two results buffered, FSM parks, queue then fills.
        res_ready = 1'b0;
        for (int t = 4; t < 8; t++) begin
            expect_res(4'(t), 32'd100 + 32'(t));
            push(32'(t), 32'd100, 32'd0, 5'b10000, 1'b0, 4'(t));
        end
        repeat (8) step();
        chk("s3_res_valid", 32'(res_valid), 32'd1);
        chk("s3_head_tag", 32'(res_tag), 32'd4);
        chk("s3_head_data", res_data, 32'd104);
        chk("s3_count", 32'(count), 32'd2);
        chk("s3_state", 32'(dbg_state), 32'd0);
        expect_res(4'd8, 32'd108);
        push(32'd8, 32'd100, 32'd0, 5'b10000, 1'b0, 4'd8);
        expect_res(4'd9, 32'd109);
        push(32'd9, 32'd100, 32'd0, 5'b10000, 1'b0, 4'd9);
        chk("s3_full_count", 32'(count), 32'd4);
        chk("s3_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_a = 32'd10; in_b = 32'd100; in_inst = 5'b10000; in_tag = 4'd10;
        repeat (3) step();
        chk("s3_held_count", 32'(count), 32'd4);
        chk("s3_held_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        res_ready = 1'b1;
        drain("s3_drain");

        // NOP between two ALU ops is dropped without touching the FU.
        expect_res(4'd11, 32'd15);
        push(32'd7, 32'd8, 32'd0, 5'b10000, 1'b0, 4'd11);
        drain("s4a_drain");
        push(32'd9, 32'd9, 32'd9, 5'b00011, 1'b1, 4'd12);
        chk("s4_nop_count", 32'(count), 32'd1);
        step();
        chk("s4_nop_dropped", 32'(count), 32'd0);
        chk("s4_nop_fu_inst", 32'(fu_inst), 32'd0);
        chk("s4_nop_state", 32'(dbg_state), 32'd0);
        step();
        chk("s4_nop_fu_inst2", 32'(fu_inst), 32'd0);
        chk("s4_nop_no_res", 32'(res_valid), 32'd0);
        expect_res(4'd13, 32'd3);
        push(32'd1, 32'd1, 32'd0, 5'b10000, 1'b1, 4'd13);
        drain("s4b_drain");
        chk("results_seen", 32'(res_seen), 32'd13);
`ifdef FUIQ_PERF_EN
        chk("perf_issued", 32'(perf_issued), 32'd13);
        checks++;
        assert (perf_stall != 16'd0) else begin
            failures++;
            $error("FAIL perf_stall observed=%0h expected=nonzero", perf_stall);
        end
`else
        chk("perf_issued_off", 32'(perf_issued), 32'd0);
        chk("perf_stall_off", 32'(perf_stall), 32'd0);
`endif

        // Reset during EXEC discards the op in flight and the queued op.
        push(32'd2, 32'd2, 32'd0, 5'b10000, 1'b0, 4'd14);
        push(32'd3, 32'd3, 32'd0, 5'b10000, 1'b0, 4'd15);
        chk("s5_state_exec", 32'(dbg_state), 32'd1);
        chk("s5_count_pre", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s5_fu_inst", 32'(fu_inst), 32'd0);
        chk("s5_count", 32'(count), 32'd0);
        chk("s5_res_valid", 32'(res_valid), 32'd0);
        chk("s5_in_ready", 32'(in_ready), 32'd0);
        chk("s5_state", 32'(dbg_state), 32'd0);
        step(); step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("s5_no_result", 32'(res_valid), 32'd0);
        chk("s5_results_seen", 32'(res_seen), 32'd13);
        chk("s5_count_after", 32'(count), 32'd0);
        chk("s5_perf_cleared", 32'(perf_issued), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
